// File: rtl/cpu_controller.sv
// -----------------------------------------------------------------------------
// cpu_controller
//
// Control FSM for the simple RISC CPU datapath. Every instruction is fetched
// through the datapath's PC/IR path (IF1 -> IF2 -> UPD), then decoded from
// IRout (DEC). The FSM then walks through the datapath micro-steps that the
// instruction needs. All control outputs are Moore outputs: they are decoded
// from the current state, with the register indices taken from IR fields.
//
// Parameters:
//   HALT_ON_ILLEGAL  1: an undefined opcode/op enters HALT
//                    0: an undefined opcode/op behaves as a NOP (back to IF1)
//
// Ports:
//   clk         in   1   rising-edge clock
//   reset       in   1   asynchronous active-high reset, forces state RST
//   IRout       in  16   current instruction held in the datapath IR
//   status      in   3   {V,N,Z} flags; not used for sequencing
//   loadPC      out  1   PC <= PC + 1
//   msel        out  1   memory address select: 0 = PC, 1 = datapath_out[7:0]
//   mwrite      out  1   memory write enable (write data = B register)
//   loadIR      out  1   IR <= mdata
//   sximm5      out 16   sign-extended IRout[4:0] (combinational)
//   sximm8      out 16   sign-extended IRout[7:0] (combinational)
//   writenum    out  3   register file write index
//   write       out  1   register file write enable
//   readnum     out  3   register file read index
//   vsel        out  4   one-hot writeback select: [0]=C [1]=PC [2]=sximm8 [3]=mdata
//   asel        out  1   1: ALU A input forced to 0
//   bsel        out  1   1: ALU B input = sximm5
//   shiftinput  out  2   shifter operation
//   loada/b/c/s out  1   A, B, C and status register loads
//   ALUop       out  2   00 ADD, 01 SUB(CMP), 10 AND, 11 NOT B
//   halted      out  1   high while in HALT
//   state_out   out  4   current state encoding (debug)
// -----------------------------------------------------------------------------
module cpu_controller #(
  parameter logic HALT_ON_ILLEGAL = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] IRout,
  input  logic [2:0]  status,
  output logic        loadPC,
  output logic        msel,
  output logic        mwrite,
  output logic        loadIR,
  output logic [15:0] sximm5,
  output logic [15:0] sximm8,
  output logic [2:0]  writenum,
  output logic        write,
  output logic [2:0]  readnum,
  output logic [3:0]  vsel,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  shiftinput,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic [1:0]  ALUop,
  output logic        halted,
  output logic [3:0]  state_out
);

  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    S_IF1  = 4'd1,
    S_IF2  = 4'd2,
    S_UPD  = 4'd3,
    S_DEC  = 4'd4,
    S_WIMM = 4'd5,
    S_GETA = 4'd6,
    S_GETB = 4'd7,
    S_EXEC = 4'd8,
    S_WREG = 4'd9,
    S_ADDR = 4'd10,
    S_MRD  = 4'd11,
    S_WMEM = 4'd12,
    S_GETD = 4'd13,
    S_MWR  = 4'd14,
    S_HALT = 4'd15
  } state_t;

  state_t r_state;
  state_t w_next;

  // Instruction fields
  logic [2:0] w_opcode;
  logic [1:0] w_op;
  logic [2:0] w_rn;
  logic [2:0] w_rd;
  logic [1:0] w_sh;
  logic [2:0] w_rm;

  // Instruction classes
  logic w_is_movi;
  logic w_is_movr;
  logic w_is_addand;
  logic w_is_cmp;
  logic w_is_mvn;
  logic w_is_ldr;
  logic w_is_str;
  logic w_is_halt;

  // The flags are exported by the datapath for debug only; sequencing
  // never looks at them.
  logic w_unused_status;
  assign w_unused_status = ^status;

  assign w_opcode = IRout[15:13];
  assign w_op     = IRout[12:11];
  assign w_rn     = IRout[10:8];
  assign w_rd     = IRout[7:5];
  assign w_sh     = IRout[4:3];
  assign w_rm     = IRout[2:0];

  assign w_is_movi   = (w_opcode == 3'b110) && (w_op == 2'b10);
  assign w_is_movr   = (w_opcode == 3'b110) && (w_op == 2'b00);
  assign w_is_addand = (w_opcode == 3'b101) && ((w_op == 2'b00) || (w_op == 2'b10));
  assign w_is_cmp    = (w_opcode == 3'b101) && (w_op == 2'b01);
  assign w_is_mvn    = (w_opcode == 3'b101) && (w_op == 2'b11);
  assign w_is_ldr    = (w_opcode == 3'b011) && (w_op == 2'b00);
  assign w_is_str    = (w_opcode == 3'b100) && (w_op == 2'b00);
  assign w_is_halt   = (w_opcode == 3'b111);

  // Immediates are pure wiring and follow IRout at all times.
  assign sximm5 = {{11{IRout[4]}}, IRout[4:0]};
  assign sximm8 = {{8{IRout[7]}}, IRout[7:0]};

  assign state_out = r_state;

  // State register; reset lands in RST asynchronously, even mid-instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_RST;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: fetch, decode, then the per-instruction micro-sequence.
  always_comb begin
    w_next = S_RST;
    case (r_state)
      S_RST:  w_next = S_IF1;
      S_IF1:  w_next = S_IF2;
      S_IF2:  w_next = S_UPD;
      S_UPD:  w_next = S_DEC;
      S_DEC: begin
        if (w_is_movi) begin
          w_next = S_WIMM;
        end else if (w_is_movr || w_is_mvn) begin
          // Single-operand forms only need B.
          w_next = S_GETB;
        end else if (w_is_addand || w_is_cmp || w_is_ldr || w_is_str) begin
          w_next = S_GETA;
        end else if (w_is_halt) begin
          w_next = S_HALT;
        end else if (HALT_ON_ILLEGAL) begin
          w_next = S_HALT;
        end else begin
          w_next = S_IF1;
        end
      end
      S_WIMM: w_next = S_IF1;
      S_GETA: begin
        // Memory ops use A as the base address, ALU ops go on to fetch B.
        if (w_is_ldr || w_is_str) begin
          w_next = S_ADDR;
        end else begin
          w_next = S_GETB;
        end
      end
      S_GETB: w_next = S_EXEC;
      S_EXEC: begin
        // CMP only updates the status register, nothing is written back.
        if (w_is_cmp) begin
          w_next = S_IF1;
        end else begin
          w_next = S_WREG;
        end
      end
      S_WREG: w_next = S_IF1;
      S_ADDR: begin
        if (w_is_str) begin
          w_next = S_GETD;
        end else begin
          w_next = S_MRD;
        end
      end
      S_MRD:  w_next = S_WMEM;
      S_WMEM: w_next = S_IF1;
      S_GETD: w_next = S_MWR;
      S_MWR:  w_next = S_IF1;
      S_HALT: w_next = S_HALT;
      default: w_next = S_RST;
    endcase
  end

  // Moore output decode; anything not named for a state stays 0.
  always_comb begin
    loadPC     = 1'b0;
    msel       = 1'b0;
    mwrite     = 1'b0;
    loadIR     = 1'b0;
    writenum   = 3'd0;
    write      = 1'b0;
    readnum    = 3'd0;
    vsel       = 4'b0000;
    asel       = 1'b0;
    bsel       = 1'b0;
    shiftinput = 2'b00;
    loada      = 1'b0;
    loadb      = 1'b0;
    loadc      = 1'b0;
    loads      = 1'b0;
    ALUop      = 2'b00;
    halted     = 1'b0;
    case (r_state)
      S_IF1: begin
        msel = 1'b0;
      end
      S_IF2: begin
        msel   = 1'b0;
        loadIR = 1'b1;
      end
      S_UPD: begin
        loadPC = 1'b1;
      end
      S_WIMM: begin
        writenum = w_rn;
        vsel     = 4'b0100;
        write    = 1'b1;
      end
      S_GETA: begin
        readnum = w_rn;
        loada   = 1'b1;
      end
      S_GETB: begin
        readnum = w_rm;
        loadb   = 1'b1;
      end
      S_EXEC: begin
        shiftinput = w_sh;
        if (w_is_movr) begin
          // MOV Rd,Rm is computed as 0 + shifted B.
          asel  = 1'b1;
          ALUop = 2'b00;
        end else begin
          ALUop = w_op;
        end
        if (w_is_cmp) begin
          loads = 1'b1;
        end else begin
          loadc = 1'b1;
        end
      end
      S_WREG: begin
        writenum = w_rd;
        vsel     = 4'b0001;
        write    = 1'b1;
      end
      S_ADDR: begin
        // Effective address = Rn + sximm5, latched into C.
        asel       = 1'b0;
        bsel       = 1'b1;
        shiftinput = 2'b00;
        ALUop      = 2'b00;
        loadc      = 1'b1;
      end
      S_MRD: begin
        msel = 1'b1;
      end
      S_WMEM: begin
        msel     = 1'b1;
        writenum = w_rd;
        vsel     = 4'b1000;
        write    = 1'b1;
      end
      S_GETD: begin
        readnum = w_rd;
        loadb   = 1'b1;
      end
      S_MWR: begin
        msel   = 1'b1;
        mwrite = 1'b1;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        halted = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
Control FSM for the simple RISC CPU datapath. It fetches each instruction via the datapath's PC/IR path, decodes IRout, and sequences every datapath control input (register file, A/B/C/status loads, ALU/shifter selects, memory select/write, PC increment). The datapath consumes these controls; this block consumes the datapath's IRout and status.

Parameters:
HALT_ON_ILLEGAL, 0, 1: an undefined opcode enters HALT; 0: it is treated as a NOP and the FSM returns to IF1.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high; forces state RST
IRout  input  16  current instruction from datapath IR
status  input  3  {V,N,Z} flags; not used for sequencing, exported for debug
loadPC  output  1  PC <= PC+1
msel  output  1  memory address: 0=PC, 1=datapath_out[7:0]
mwrite  output  1  memory write enable (write data = B register)
loadIR  output  1  IR <= mdata
sximm5  output  16  sign-extended IRout[4:0], combinational
sximm8  output  16  sign-extended IRout[7:0], combinational
writenum  output  3  register file write index
write  output  1  register file write enable
readnum  output  3  register file read index
vsel  output  4  one-hot writeback: [0]=C, [1]={8'b0,PC}, [2]=sximm8, [3]=mdata
asel  output  1  1: ALU A input = 0
bsel  output  1  1: ALU B input = sximm5
shiftinput  output  2  shifter op
loada, loadb, loadc, loads  output  1 each  register loads
ALUop  output  2  00 ADD, 01 SUB(CMP), 10 AND, 11 NOT B
halted  output  1  high in HALT
state_out  output  4  current state encoding, debug

Behaviour:
- Fields: opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0].
- Moore outputs decoded from state (plus IR fields); every output not listed for a state is 0, vsel=0000. sximm5/sximm8 are always driven.
- Reset: state=RST immediately, asynchronously, including mid-instruction; all outputs 0 while reset is high. The datapath zeroes PC itself.
- RST -> IF1. IF1: msel=0. IF2: msel=0, loadIR=1. UPD: loadPC=1. DEC: no outputs; branches on opcode/op.
- MOV imm (110,10): WIMM: writenum=Rn, vsel=0100, write=1 -> IF1. Total 5 cycles.
- MOV reg (110,00): GETB -> EXEC(asel=1, ALUop=00, shiftinput=sh, loadc=1) -> WREG(writenum=Rd, vsel=0001, write=1). 7 cycles.
- ADD/AND (101,00/10): GETA(readnum=Rn, loada=1) -> GETB(readnum=Rm, loadb=1) -> EXEC(ALUop=op, shiftinput=sh, loadc=1) -> WREG. 8 cycles.
- CMP (101,01): GETA -> GETB -> EXEC with loads=1 and loadc=0 -> IF1, no write. 7 cycles.
- MVN (101,11): GETB -> EXEC(ALUop=11) -> WREG. 7 cycles.
- LDR (011,00): GETA(Rn) -> ADDR(asel=0, bsel=1, shiftinput=00, ALUop=00, loadc=1) -> MRD(msel=1) -> WMEM(msel=1, writenum=Rd, vsel=1000, write=1). 8 cycles.
- STR (100,00): GETA(Rn) -> ADDR -> GETD(readnum=Rd, loadb=1) -> MWR(msel=1, mwrite=1). 8 cycles.
- HALT (111): HALT state, halted=1, all other outputs 0; stays until reset.
- Any other opcode/op: HALT if HALT_ON_ILLEGAL=1, else IF1.
- mwrite is high for exactly one cycle per STR and never otherwise. loadPC is high exactly once per fetched instruction.

Test Plan:
- Reset high 15 ns then low -> all outputs 0 during reset; IF1, IF2(loadIR=1), UPD(loadPC=1) follow on successive edges.
- IR=0xD007 (MOV R0,#7) -> sximm8=0x0007, WIMM has writenum=0, vsel=0100, write=1; back in IF1 5 cycles after IF1. IR=0xD1FE -> sximm8=0xFFFE.
- IR=0xA148 (ADD R2,R1,R0,LSL#1) -> GETA readnum=1/loada; GETB readnum=0/loadb; EXEC shiftinput=01, ALUop=00, loadc; WREG writenum=2, vsel=0001. IR=0xA900 (CMP R1,R0) -> loads=1 in EXEC, write never asserted, 7 cycles.
- IR=0x6062 (LDR R3,[R0,#2]) -> sximm5=2, ADDR bsel=1/loadc; WMEM writenum=3, vsel=1000, msel=1. IR=0x807F (STR R3,[R0,#-1]) -> sximm5=0xFFFF, single mwrite cycle with msel=1.
- IR=0xE000 -> halted=1 held for 10 cycles; with HALT_ON_ILLEGAL=0, IR=0x0000 returns to IF1 after DEC.
- Assert reset mid-EXEC of ADD -> loadc drops in the same timestep; after release, sequence restarts at RST -> IF1.
